// File: rtl/packet_forwarder_if.sv
// -----------------------------------------------------------------------------
// Shared flit/packet types and the bus interface of packet_forwarder.
//
// types::flit_t                   : 2-bit flit type + 30-bit payload (32 bits)
// packet_types::packet_element_t  : PACKET_MAX_FLITS stored flits + tail_index
//                                   (number of valid flits, legal 1..MAX)
//
// packet_forwarder_if groups both handshakes seen by the forwarder:
//   transfered_packet           upstream -> forwarder  head-of-queue packet
//   transfered_packet_valid     upstream -> forwarder  packet present
//   transfered_packet_completed forwarder -> upstream  one-cycle pop/free
//   out_flit                    forwarder -> downstream flit offered
//   out_flit_valid              forwarder -> downstream flit valid
//   out_flit_ready              downstream -> forwarder flit accepted
// modport master : the forwarder's view
// modport slave  : the environment's view (upstream buffer + downstream sink)
// -----------------------------------------------------------------------------
package types;
    typedef enum logic [1:0] {
        FLIT_HEAD     = 2'd0,
        FLIT_BODY     = 2'd1,
        FLIT_TAIL     = 2'd2,
        FLIT_HEADTAIL = 2'd3
    } flit_type_t;

    typedef struct packed {
        flit_type_t  ftype;
        logic [29:0] payload;
    } flit_t;
endpackage

package packet_types;
    localparam int PACKET_MAX_FLITS = 8;
    // One extra bit so that out-of-range values (0 and MAX+1) are representable.
    localparam int TAIL_INDEX_WIDTH = $clog2(PACKET_MAX_FLITS) + 1;

    typedef struct packed {
        types::flit_t [PACKET_MAX_FLITS-1:0] buffer;
        logic [TAIL_INDEX_WIDTH-1:0]         tail_index;
    } packet_element_t;
endpackage

interface packet_forwarder_if;
    packet_types::packet_element_t transfered_packet;
    logic                          transfered_packet_valid;
    logic                          transfered_packet_completed;
    types::flit_t                  out_flit;
    logic                          out_flit_valid;
    logic                          out_flit_ready;

    modport master (
        input  transfered_packet,
        input  transfered_packet_valid,
        output transfered_packet_completed,
        output out_flit,
        output out_flit_valid,
        input  out_flit_ready
    );

    modport slave (
        output transfered_packet,
        output transfered_packet_valid,
        input  transfered_packet_completed,
        input  out_flit,
        input  out_flit_valid,
        output out_flit_ready
    );
endinterface

// File: rtl/packet_forwarder.sv
// -----------------------------------------------------------------------------
// packet_forwarder
// Downstream stage of the packet reassembly buffer. Takes one completed packet
// at a time and serialises its stored flits, in order, onto a single
// valid/ready flit stream. After the last flit is accepted it pulses
// transfered_packet_completed for one cycle so upstream frees the entry.
// Out-of-range tail_index packets are dropped (still popped); a packet whose
// valid disappears mid-send is aborted (not popped).
//
// Ports:
//   nocclk                in   clock
//   rst_n                 in   asynchronous reset, active low
//   bus                   master modport of packet_forwarder_if (packet in,
//                         completed pop out, flit valid/ready out)
//   busy                  out  FSM not idle
//   packet_sent_count     out  packets fully forwarded (saturating)
//   packet_dropped_count  out  packets dropped or aborted (saturating)
//
// PACKET_MAX_FLITS must match packet_types::PACKET_MAX_FLITS, since the
// packet struct layout comes from that package.
// -----------------------------------------------------------------------------
module packet_forwarder #(
    parameter int PACKET_MAX_FLITS = packet_types::PACKET_MAX_FLITS,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic                   nocclk,
    input  logic                   rst_n,
    packet_forwarder_if.master     bus,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] packet_sent_count,
    output logic [COUNT_WIDTH-1:0] packet_dropped_count
);

    // idx/len carry one extra bit so len==PACKET_MAX_FLITS fits and idx never wraps.
    localparam int IDX_W = $clog2(PACKET_MAX_FLITS) + 1;
    localparam int SEL_W = $clog2(PACKET_MAX_FLITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic [IDX_W-1:0]       idx_q,       idx_d;
    logic [IDX_W-1:0]       len_q,       len_d;
    types::flit_t           out_flit_q,  out_flit_d;
    logic                   out_valid_q, out_valid_d;
    logic                   completed_q, completed_d;
    logic                   busy_q,      busy_d;
    logic [COUNT_WIDTH-1:0] sent_q,      sent_d;
    logic [COUNT_WIDTH-1:0] dropped_q,   dropped_d;

    logic [IDX_W-1:0] tail_index;
    logic             tail_ok;
    logic             handshake;
    logic [SEL_W-1:0] next_sel;

    assign tail_index = bus.transfered_packet.tail_index;
    assign tail_ok    = (tail_index != '0) && (tail_index <= IDX_W'(PACKET_MAX_FLITS));
    assign handshake  = out_valid_q & bus.out_flit_ready;
    // Only used when idx_q < len_q-1, so idx_q+1 always addresses a stored flit.
    assign next_sel   = SEL_W'(idx_q + 1'b1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        out_flit_d  = out_flit_q;
        out_valid_d = out_valid_q;
        sent_d      = sent_q;
        dropped_d   = dropped_q;

        case (state_q)
            IDLE: begin
                if (bus.transfered_packet_valid) begin
                    if (tail_ok) begin
                        len_d       = tail_index;
                        idx_d       = '0;
                        out_flit_d  = bus.transfered_packet.buffer[0];
                        out_valid_d = 1'b1;
                        state_d     = SEND;
                    end else begin
                        // Malformed packet: pop it without emitting anything.
                        if (dropped_q != '1) dropped_d = dropped_q + 1'b1;
                        state_d = DONE;
                    end
                end
            end
            SEND: begin
                if (!bus.transfered_packet_valid) begin
                    // Upstream withdrew the packet: abandon it and do not pop.
                    out_valid_d = 1'b0;
                    if (dropped_q != '1) dropped_d = dropped_q + 1'b1;
                    state_d = IDLE;
                end else if (handshake) begin
                    if (idx_q == len_q - 1'b1) begin
                        out_valid_d = 1'b0;
                        if (sent_q != '1) sent_d = sent_q + 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        out_flit_d = bus.transfered_packet.buffer[next_sel];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered so the pop pulse and busy line up exactly with the state.
        completed_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            out_flit_q  <= '0;
            out_valid_q <= 1'b0;
            completed_q <= 1'b0;
            busy_q      <= 1'b0;
            sent_q      <= '0;
            dropped_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            out_flit_q  <= out_flit_d;
            out_valid_q <= out_valid_d;
            completed_q <= completed_d;
            busy_q      <= busy_d;
            sent_q      <= sent_d;
            dropped_q   <= dropped_d;
        end
    end

    assign bus.out_flit                    = out_flit_q;
    assign bus.out_flit_valid              = out_valid_q;
    assign bus.transfered_packet_completed = completed_q;
    assign busy                            = busy_q;
    assign packet_sent_count               = sent_q;
    assign packet_dropped_count            = dropped_q;

endmodule

// File: tb/tb_packet_forwarder.sv
// -----------------------------------------------------------------------------
// Directed testbench for packet_forwarder. Inputs change 1 time unit after
// each rising edge, outputs are sampled at the same point. A second instance
// with 2-bit counters shares the stimulus to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_packet_forwarder;

    logic nocclk;
    logic rst_n;
    logic busy;
    logic [15:0] sent;
    logic [15:0] dropped;
    logic small_busy;
    logic [1:0] small_sent;
    logic [1:0] small_dropped;

    int errors = 0;
    int checks = 0;

    packet_types::packet_element_t pkt;

    packet_forwarder_if bif ();
    packet_forwarder_if sif ();

    assign sif.transfered_packet       = bif.transfered_packet;
    assign sif.transfered_packet_valid = bif.transfered_packet_valid;
    assign sif.out_flit_ready          = bif.out_flit_ready;

    packet_forwarder #(.PACKET_MAX_FLITS(8), .COUNT_WIDTH(16)) dut (
        .nocclk               (nocclk),
        .rst_n                (rst_n),
        .bus                  (bif.master),
        .busy                 (busy),
        .packet_sent_count    (sent),
        .packet_dropped_count (dropped)
    );

    packet_forwarder #(.PACKET_MAX_FLITS(8), .COUNT_WIDTH(2)) dut_small (
        .nocclk               (nocclk),
        .rst_n                (rst_n),
        .bus                  (sif.master),
        .busy                 (small_busy),
        .packet_sent_count    (small_sent),
        .packet_dropped_count (small_dropped)
    );

    initial nocclk = 1'b0;
    always #5 nocclk = ~nocclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge nocclk);
        #1;
    endtask

    function automatic packet_types::packet_element_t make_pkt(input int tail, input logic [29:0] base);
        packet_types::packet_element_t p;
        p = '0;
        p.tail_index = 4'(tail);
        for (int i = 0; i < 8; i++) begin
            p.buffer[i].payload = base + 30'(i);
            if (tail == 1 && i == 0)  p.buffer[i].ftype = types::FLIT_HEADTAIL;
            else if (i == 0)          p.buffer[i].ftype = types::FLIT_HEAD;
            else if (i == tail - 1)   p.buffer[i].ftype = types::FLIT_TAIL;
            else                      p.buffer[i].ftype = types::FLIT_BODY;
        end
        return p;
    endfunction

    task automatic load(input packet_types::packet_element_t p);
        bif.transfered_packet       = p;
        bif.transfered_packet_valid = 1'b1;
    endtask

    // Drop-path check: one cycle in DONE with no flit, then back to idle.
    task automatic drop_one(input int tail, input string tag);
        load(make_pkt(tail, 30'h3f0));
        tick();
        check({tag, "_valid"}, 64'(bif.out_flit_valid), 64'd0);
        check({tag, "_cmp"}, 64'(bif.transfered_packet_completed), 64'd1);
        bif.transfered_packet_valid = 1'b0;
        tick();
        check({tag, "_cmp_low"}, 64'(bif.transfered_packet_completed), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    logic rdy_tab [4];
    int   eidx_tab [4];

    initial begin
        rst_n = 1'b0;
        bif.transfered_packet       = '0;
        bif.transfered_packet_valid = 1'b0;
        bif.out_flit_ready          = 1'b0;
        repeat (2) @(posedge nocclk);
        #1;
        check("rst_valid",   64'(bif.out_flit_valid), 64'd0);
        check("rst_flit",    64'(bif.out_flit), 64'd0);
        check("rst_cmp",     64'(bif.transfered_packet_completed), 64'd0);
        check("rst_busy",    64'(busy), 64'd0);
        check("rst_sent",    64'(sent), 64'd0);
        check("rst_dropped", 64'(dropped), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: 3-flit packet, ready held high.
        pkt = make_pkt(3, 30'h100);
        load(pkt);
        bif.out_flit_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_valid", 64'(bif.out_flit_valid), 64'd1);
            check("t1_flit",  64'(bif.out_flit), 64'(pkt.buffer[i]));
            check("t1_cmp",   64'(bif.transfered_packet_completed), 64'd0);
            check("t1_busy",  64'(busy), 64'd1);
        end
        check("t1_last_payload", 64'(bif.out_flit.payload), 64'h102);
        tick();
        check("t1_done_valid", 64'(bif.out_flit_valid), 64'd0);
        check("t1_done_cmp",   64'(bif.transfered_packet_completed), 64'd1);
        check("t1_sent",       64'(sent), 64'd1);
        bif.transfered_packet_valid = 1'b0;
        tick();
        check("t1_cmp_low", 64'(bif.transfered_packet_completed), 64'd0);
        check("t1_idle",    64'(busy), 64'd0);

        // 2: ready pattern 1,0,0,1,1 with flit held while ready is low.
        pkt = make_pkt(3, 30'h180);
        load(pkt);
        bif.out_flit_ready = 1'b0;
        tick();
        check("t2_flit0", 64'(bif.out_flit), 64'(pkt.buffer[0]));
        check("t2_valid0", 64'(bif.out_flit_valid), 64'd1);
        rdy_tab  = '{1'b1, 1'b0, 1'b0, 1'b1};
        eidx_tab = '{1, 1, 1, 2};
        for (int k = 0; k < 4; k++) begin
            bif.out_flit_ready = rdy_tab[k];
            tick();
            check("t2_flit",  64'(bif.out_flit), 64'(pkt.buffer[eidx_tab[k]]));
            check("t2_valid", 64'(bif.out_flit_valid), 64'd1);
            check("t2_cmp",   64'(bif.transfered_packet_completed), 64'd0);
        end
        bif.out_flit_ready = 1'b1;
        tick();
        check("t2_done_valid", 64'(bif.out_flit_valid), 64'd0);
        check("t2_done_cmp",   64'(bif.transfered_packet_completed), 64'd1);
        check("t2_sent",       64'(sent), 64'd2);
        bif.transfered_packet_valid = 1'b0;
        tick();
        check("t2_cmp_low", 64'(bif.transfered_packet_completed), 64'd0);

        // 3: two queued packets (2 flits, then 1 flit).
        pkt = make_pkt(2, 30'h200);
        load(pkt);
        tick();
        check("t3a_flit0", 64'(bif.out_flit), 64'(pkt.buffer[0]));
        tick();
        check("t3a_flit1", 64'(bif.out_flit), 64'(pkt.buffer[1]));
        tick();
        check("t3a_cmp",   64'(bif.transfered_packet_completed), 64'd1);
        pkt = make_pkt(1, 30'h300);
        load(pkt);
        tick();
        check("t3_gap_valid", 64'(bif.out_flit_valid), 64'd0);
        check("t3_gap_cmp",   64'(bif.transfered_packet_completed), 64'd0);
        tick();
        check("t3b_flit0",  64'(bif.out_flit), 64'(pkt.buffer[0]));
        check("t3b_type",   64'(bif.out_flit.ftype), 64'(types::FLIT_HEADTAIL));
        check("t3b_valid",  64'(bif.out_flit_valid), 64'd1);
        tick();
        check("t3b_cmp",    64'(bif.transfered_packet_completed), 64'd1);
        check("t3_sent",    64'(sent), 64'd4);
        bif.transfered_packet_valid = 1'b0;
        tick();

        // 4: out-of-range tail_index values are dropped.
        drop_one(0, "t4_tail0");
        drop_one(9, "t4_tail9");
        check("t4_dropped", 64'(dropped), 64'd2);
        check("t4_sent",    64'(sent), 64'd4);

        // 5: valid withdrawn after the first of four flits is accepted.
        pkt = make_pkt(4, 30'h400);
        load(pkt);
        tick();
        check("t5_flit0", 64'(bif.out_flit), 64'(pkt.buffer[0]));
        tick();
        check("t5_flit1", 64'(bif.out_flit), 64'(pkt.buffer[1]));
        bif.transfered_packet_valid = 1'b0;
        tick();
        check("t5_valid",   64'(bif.out_flit_valid), 64'd0);
        check("t5_cmp",     64'(bif.transfered_packet_completed), 64'd0);
        check("t5_busy",    64'(busy), 64'd0);
        check("t5_dropped", 64'(dropped), 64'd3);
        tick();
        check("t5_cmp_after", 64'(bif.transfered_packet_completed), 64'd0);
        check("t5_sent",      64'(sent), 64'd4);

        // 6: asynchronous reset mid-send, then a normal packet.
        pkt = make_pkt(3, 30'h500);
        load(pkt);
        tick();
        tick();
        check("t6_pre_flit", 64'(bif.out_flit), 64'(pkt.buffer[1]));
        rst_n = 1'b0;
        bif.transfered_packet_valid = 1'b0;
        #1;
        check("t6_rst_valid",   64'(bif.out_flit_valid), 64'd0);
        check("t6_rst_flit",    64'(bif.out_flit), 64'd0);
        check("t6_rst_busy",    64'(busy), 64'd0);
        check("t6_rst_dropped", 64'(dropped), 64'd0);
        check("t6_rst_sent",    64'(sent), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_post_cmp", 64'(bif.transfered_packet_completed), 64'd0);
        pkt = make_pkt(2, 30'h600);
        load(pkt);
        tick();
        check("t6_flit0", 64'(bif.out_flit), 64'(pkt.buffer[0]));
        tick();
        check("t6_flit1", 64'(bif.out_flit), 64'(pkt.buffer[1]));
        tick();
        check("t6_cmp",  64'(bif.transfered_packet_completed), 64'd1);
        check("t6_sent", 64'(sent), 64'd1);
        check("t6_small_sent", 64'(small_sent), 64'd1);
        bif.transfered_packet_valid = 1'b0;
        tick();

        // Counter saturation: four drops on 16-bit and 2-bit counters.
        drop_one(0, "sat0");
        drop_one(9, "sat1");
        drop_one(0, "sat2");
        drop_one(15, "sat3");
        check("sat_dropped16", 64'(dropped), 64'd4);
        check("sat_dropped2",  64'(small_dropped), 64'd3);
        check("sat_small_busy", 64'(small_busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
